// File: rtl/branch_resolve_if.sv
// branch_resolve_if: D-stage branch request, prediction lookup, resolved
// PC-select/flush outputs and statistics counters of the branch-resolution
// unit. WIDTH and CNT_W must match the parameters of the attached
// branch_resolve instance.
interface branch_resolve_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
);
    logic             valid_in;
    logic             stall_in;
    logic [3:0]       op;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic [WIDTH-1:0] lookup_pc;
    logic             clr_stats;
    logic             predict_taken;
    logic             out_valid;
    logic [2:0]       pc_sel;
    logic             flush;
    logic             mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    // D stage / pipeline control side
    modport master (
        output valid_in, stall_in, op, pc, rs, rt, lookup_pc, clr_stats,
        input  predict_taken, out_valid, pc_sel, flush, mispredict,
               branch_cnt, mispredict_cnt
    );

    // Branch-resolution unit side
    modport slave (
        input  valid_in, stall_in, op, pc, rs, rt, lookup_pc, clr_stats,
        output predict_taken, out_valid, pc_sel, flush, mispredict,
               branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: resolves P5 D-stage branches/jumps, registers the PC-select,
// flush and mispredict decision one cycle later, trains a table of 2-bit
// saturating counters and keeps saturating branch/mispredict statistics.
// Optional feature macro: BRANCH_PRED_EN. When undefined no predictor table
// exists, prediction is static not-taken, so every taken conditional op is
// reported as a mispredict.
module branch_resolve #(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 32
) (
    input  logic           clk,
    input  logic           reset,
    branch_resolve_if.slave bus
);
    localparam int IW = $clog2(BHT_DEPTH);

    localparam logic [3:0] OP_BEQ  = 4'd1;
    localparam logic [3:0] OP_J    = 4'd2;
    localparam logic [3:0] OP_JR   = 4'd3;
    localparam logic [3:0] OP_BEQL = 4'd4;
    localparam logic [3:0] OP_BNE  = 4'd5;
    localparam logic [3:0] OP_BLEZ = 4'd6;
    localparam logic [3:0] OP_BGTZ = 4'd7;
    localparam logic [3:0] OP_BLTZ = 4'd8;
    localparam logic [3:0] OP_BGEZ = 4'd9;

    localparam logic [2:0] SEL_SEQ = 3'b000;
    localparam logic [2:0] SEL_BR  = 3'b001;
    localparam logic [2:0] SEL_J   = 3'b010;
    localparam logic [2:0] SEL_JR  = 3'b011;

    // Step a 2-bit predictor counter towards taken or not-taken, saturating.
    function automatic logic [1:0] sat2_next(input logic [1:0] cur, input logic up);
        logic [1:0] nxt;
        nxt = cur;
        if (up) begin
            if (cur != 2'b11) nxt = cur + 2'b01;
            else              nxt = cur;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'b01;
            else              nxt = cur;
        end
        return nxt;
    endfunction

    // Increment a statistics counter, holding at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] stat_next(input logic [CNT_W-1:0] cur, input logic inc);
        logic [CNT_W-1:0] nxt;
        nxt = cur;
        if (inc && (cur != {CNT_W{1'b1}})) nxt = cur + {{(CNT_W-1){1'b0}}, 1'b1};
        else                               nxt = cur;
        return nxt;
    endfunction

    logic             rs_eq_rt_s;
    logic             rs_neg_s;
    logic             rs_zero_s;
    logic             op_ok_s;
    logic             cond_s;
    logic             taken_s;
    logic             accept_s;
    logic             upd_s;
    logic             flush_s;
    logic             pred_bit_s;
    logic             mispredict_s;
    logic [2:0]       jump_sel_s;
    logic [2:0]       pc_sel_s;

    logic             out_valid_r;
    logic [2:0]       pc_sel_r;
    logic             flush_r;
    logic             mispredict_r;
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] mispredict_cnt_r;

    // Operand relations shared by all conditional ops (rt only matters for eq/ne)
    always_comb begin
        rs_eq_rt_s = (bus.rs == bus.rt);
        rs_neg_s   = bus.rs[WIDTH-1];
        rs_zero_s  = (bus.rs == {WIDTH{1'b0}});
    end

    // Decode the op class, evaluate the taken condition and choose the PC source
    always_comb begin
        op_ok_s    = 1'b1;
        cond_s     = 1'b0;
        taken_s    = 1'b0;
        jump_sel_s = SEL_SEQ;
        case (bus.op)
            OP_BEQ:  begin cond_s = 1'b1; taken_s = rs_eq_rt_s;             end
            OP_J:    begin jump_sel_s = SEL_J;                               end
            OP_JR:   begin jump_sel_s = SEL_JR;                              end
            OP_BEQL: begin cond_s = 1'b1; taken_s = rs_eq_rt_s;             end
            OP_BNE:  begin cond_s = 1'b1; taken_s = !rs_eq_rt_s;            end
            OP_BLEZ: begin cond_s = 1'b1; taken_s = rs_neg_s || rs_zero_s;  end
            OP_BGTZ: begin cond_s = 1'b1; taken_s = !rs_neg_s && !rs_zero_s; end
            OP_BLTZ: begin cond_s = 1'b1; taken_s = rs_neg_s;               end
            OP_BGEZ: begin cond_s = 1'b1; taken_s = !rs_neg_s;              end
            default: begin op_ok_s = 1'b0;                                   end
        endcase

        accept_s = bus.valid_in && !bus.stall_in && op_ok_s;
        upd_s    = accept_s && cond_s;

        if (!accept_s) begin
            pc_sel_s = SEL_SEQ;
        end else if (cond_s) begin
            pc_sel_s = taken_s ? SEL_BR : SEL_SEQ;
        end else begin
            pc_sel_s = jump_sel_s;
        end

        // Likely branches squash the delay slot only when they fall through
        flush_s      = accept_s && (bus.op == OP_BEQL) && !taken_s;
        mispredict_s = upd_s && (pred_bit_s != taken_s);
    end

`ifdef BRANCH_PRED_EN
    logic [1:0]    bht_r [BHT_DEPTH];
    logic [IW-1:0] upd_idx_s;
    logic [IW-1:0] lk_idx_s;
    logic          unused_pc_bits_s;

    assign upd_idx_s          = bus.pc[IW+1:2];
    assign lk_idx_s           = bus.lookup_pc[IW+1:2];
    assign pred_bit_s         = bht_r[upd_idx_s][1];
    // The table is read before the edge, so a same-cycle update is not visible
    assign bus.predict_taken  = bht_r[lk_idx_s][1];
    assign unused_pc_bits_s   = ^{bus.pc[WIDTH-1:IW+2], bus.pc[1:0],
                                  bus.lookup_pc[WIDTH-1:IW+2], bus.lookup_pc[1:0]};

    // Train the counter of the resolved conditional branch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_r[i] <= 2'b01;
        end else if (upd_s) begin
            bht_r[upd_idx_s] <= sat2_next(bht_r[upd_idx_s], taken_s);
        end
    end
`else
    logic unused_pc_bits_s;

    assign pred_bit_s        = 1'b0;
    assign bus.predict_taken = 1'b0;
    assign unused_pc_bits_s  = ^{bus.pc, bus.lookup_pc};
`endif

    // Register the resolution; nothing is held across idle or stalled cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            pc_sel_r     <= SEL_SEQ;
            flush_r      <= 1'b0;
            mispredict_r <= 1'b0;
        end else begin
            out_valid_r  <= accept_s;
            pc_sel_r     <= pc_sel_s;
            flush_r      <= flush_s;
            mispredict_r <= mispredict_s;
        end
    end

    // Saturating statistics; a clear request wins over a same-cycle increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt_r     <= {CNT_W{1'b0}};
            mispredict_cnt_r <= {CNT_W{1'b0}};
        end else if (bus.clr_stats) begin
            branch_cnt_r     <= {CNT_W{1'b0}};
            mispredict_cnt_r <= {CNT_W{1'b0}};
        end else begin
            branch_cnt_r     <= stat_next(branch_cnt_r, upd_s);
            mispredict_cnt_r <= stat_next(mispredict_cnt_r, mispredict_s);
        end
    end

    assign bus.out_valid      = out_valid_r;
    assign bus.pc_sel         = pc_sel_r;
    assign bus.flush          = flush_r;
    assign bus.mispredict     = mispredict_r;
    assign bus.branch_cnt     = branch_cnt_r;
    assign bus.mispredict_cnt = mispredict_cnt_r;
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and randomized stimulus for two branch_resolve
// instances (32-bit and 4-bit statistics counters) fed identically, compared
// every cycle against a behavioural model of the branch rules.
module tb_branch_resolve;
    localparam int D = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_if #(.WIDTH(32), .CNT_W(32)) bus ();
    branch_resolve_if #(.WIDTH(32), .CNT_W(4))  bus_s ();

    branch_resolve #(.WIDTH(32), .BHT_DEPTH(D), .CNT_W(32)) dut   (.clk(clk), .reset(reset), .bus(bus));
    branch_resolve #(.WIDTH(32), .BHT_DEPTH(D), .CNT_W(4))  dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    int     n_vec = 0;
    int     n_bad = 0;
    logic   done  = 1'b0;
    logic   pt_seen;

    // model state
    int     m_tab [D];
    logic   exp_ov, exp_fl, exp_mp, exp_pt;
    logic [2:0] exp_sel;
    longint exp_bc, exp_mc, exp_bc_s, exp_mc_s;
    logic   nxt_ov, nxt_fl, nxt_mp;
    logic [2:0] nxt_sel;
    longint nxt_bc, nxt_mc, nxt_bc_s, nxt_mc_s;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic longint bump(input longint v, input logic inc, input longint mx);
        if (!inc) return v;
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [3:0] o, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] l, input logic c);
        bus.valid_in  = v; bus_s.valid_in  = v;
        bus.stall_in  = s; bus_s.stall_in  = s;
        bus.op        = o; bus_s.op        = o;
        bus.pc        = p; bus_s.pc        = p;
        bus.rs        = a; bus_s.rs        = a;
        bus.rt        = b; bus_s.rt        = b;
        bus.lookup_pc = l; bus_s.lookup_pc = l;
        bus.clr_stats = c; bus_s.clr_stats = c;
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_tab[i] = 1;
        exp_ov = 0; exp_fl = 0; exp_mp = 0; exp_pt = 0; exp_sel = 3'd0;
        exp_bc = 0; exp_mc = 0; exp_bc_s = 0; exp_mc_s = 0;
        nxt_ov = 0; nxt_fl = 0; nxt_mp = 0; nxt_sel = 3'd0;
        nxt_bc = 0; nxt_mc = 0; nxt_bc_s = 0; nxt_mc_s = 0;
    endtask

    // Evaluate the ops rules for the inputs currently applied
    task automatic model_step();
        int idx, lidx, o;
        logic acc, cond, tk, pred;
        o    = int'(bus.op);
        idx  = int'((bus.pc >> 2) % D);
        lidx = int'((bus.lookup_pc >> 2) % D);
`ifdef BRANCH_PRED_EN
        exp_pt = (m_tab[lidx] >= 2);
        pred   = (m_tab[idx] >= 2);
`else
        exp_pt = 1'b0;
        pred   = 1'b0;
`endif
        acc  = bus.valid_in && !bus.stall_in && (o >= 1) && (o <= 9);
        cond = (o == 1) || ((o >= 4) && (o <= 9));
        case (o)
            1, 4:    tk = (bus.rs == bus.rt);
            5:       tk = (bus.rs != bus.rt);
            6:       tk = ($signed(bus.rs) <= 0);
            7:       tk = ($signed(bus.rs) > 0);
            8:       tk = ($signed(bus.rs) < 0);
            9:       tk = ($signed(bus.rs) >= 0);
            default: tk = 1'b0;
        endcase
        nxt_ov  = acc;
        nxt_sel = !acc ? 3'd0 : (o == 2) ? 3'd2 : (o == 3) ? 3'd3 : (tk ? 3'd1 : 3'd0);
        nxt_fl  = acc && (o == 4) && !tk;
        nxt_mp  = acc && cond && (pred != tk);
        if (bus.clr_stats) begin
            nxt_bc = 0; nxt_mc = 0; nxt_bc_s = 0; nxt_mc_s = 0;
        end else begin
            nxt_bc   = bump(exp_bc,   acc && cond, 64'hFFFF_FFFF);
            nxt_mc   = bump(exp_mc,   nxt_mp,      64'hFFFF_FFFF);
            nxt_bc_s = bump(exp_bc_s, acc && cond, 15);
            nxt_mc_s = bump(exp_mc_s, nxt_mp,      15);
        end
        if (acc && cond) begin
            if (tk) m_tab[idx] = (m_tab[idx] == 3) ? 3 : m_tab[idx] + 1;
            else    m_tab[idx] = (m_tab[idx] == 0) ? 0 : m_tab[idx] - 1;
        end
    endtask

    // One cycle: apply at negedge, capture prediction, advance model at posedge
    task automatic step(input logic v, input logic s, input logic [3:0] o, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] l, input logic c);
        @(negedge clk);
        drive(v, s, o, p, a, b, l, c);
        model_step();
        #1 pt_seen = bus.predict_taken;
        @(posedge clk);
        exp_ov = nxt_ov; exp_sel = nxt_sel; exp_fl = nxt_fl; exp_mp = nxt_mp;
        exp_bc = nxt_bc; exp_mc = nxt_mc; exp_bc_s = nxt_bc_s; exp_mc_s = nxt_mc_s;
    endtask

    // Reset asserted mid-cycle, just after an edge that may have latched an op
    task automatic do_reset();
        #3 reset = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        model_reset();
        #1;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_branch_cnt", {32'd0, bus.branch_cnt}, 64'd0);
        @(negedge clk);
        #3 reset = 1'b0;
    endtask

    // Compare both DUTs with the model on every cycle
    always @(negedge clk) begin
        #2;
        if (!done) begin
            chk("out_valid",      {63'd0, bus.out_valid},      {63'd0, exp_ov});
            chk("pc_sel",         {61'd0, bus.pc_sel},         {61'd0, exp_sel});
            chk("flush",          {63'd0, bus.flush},          {63'd0, exp_fl});
            chk("mispredict",     {63'd0, bus.mispredict},     {63'd0, exp_mp});
            chk("predict_taken",  {63'd0, bus.predict_taken},  {63'd0, exp_pt});
            chk("branch_cnt",     {32'd0, bus.branch_cnt},     exp_bc);
            chk("mispredict_cnt", {32'd0, bus.mispredict_cnt}, exp_mc);
            chk("s_pc_sel",       {61'd0, bus_s.pc_sel},       {61'd0, exp_sel});
            chk("s_branch_cnt",   {60'd0, bus_s.branch_cnt},   exp_bc_s);
            chk("s_mispredict_cnt", {60'd0, bus_s.mispredict_cnt}, exp_mc_s);
        end
    end

    initial begin
        logic [31:0] a, b, p, l;
        logic [3:0]  o;
        logic [63:0] pt_exp;
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        #3 reset = 1'b0;
        chk("init_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("init_pc_sel", {61'd0, bus.pc_sel}, 64'd0);
        chk("init_branch_cnt", {32'd0, bus.branch_cnt}, 64'd0);
        chk("init_predict", {63'd0, bus.predict_taken}, 64'd0);

        // beq taken at 0x3000 from a fresh predictor
        step(1'b1, 1'b0, 4'd1, 32'h3000, 32'h5, 32'h5, 32'h3000, 1'b0);
        #1;
        chk("beq_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("beq_pc_sel", {61'd0, bus.pc_sel}, 64'd1);
        chk("beq_flush", {63'd0, bus.flush}, 64'd0);
        chk("beq_mispredict", {63'd0, bus.mispredict}, 64'd1);
        chk("beq_branch_cnt", {32'd0, bus.branch_cnt}, 64'd1);
        chk("beq_mispredict_cnt", {32'd0, bus.mispredict_cnt}, 64'd1);

        // stalled op is ignored
        step(1'b1, 1'b1, 4'd1, 32'h3000, 32'h5, 32'h5, 32'h3000, 1'b0);
        #1;
        chk("stall_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("stall_branch_cnt", {32'd0, bus.branch_cnt}, 64'd1);
        chk("stall_mispredict_cnt", {32'd0, bus.mispredict_cnt}, 64'd1);

        // beql not taken squashes the delay slot
        step(1'b1, 1'b0, 4'd4, 32'h3004, 32'h1, 32'h2, 32'h3004, 1'b0);
        #1;
        chk("beql_pc_sel", {61'd0, bus.pc_sel}, 64'd0);
        chk("beql_flush", {63'd0, bus.flush}, 64'd1);
        chk("beql_mispredict", {63'd0, bus.mispredict}, 64'd0);

        // sign tests on the most negative value
        step(1'b1, 1'b0, 4'd8, 32'h3040, 32'h8000_0000, 32'd0, 32'h3040, 1'b0);
        #1 chk("bltz_neg", {61'd0, bus.pc_sel}, 64'd1);
        step(1'b1, 1'b0, 4'd9, 32'h3044, 32'h8000_0000, 32'd0, 32'h3044, 1'b0);
        #1 chk("bgez_neg", {61'd0, bus.pc_sel}, 64'd0);
        step(1'b1, 1'b0, 4'd6, 32'h3048, 32'h8000_0000, 32'd0, 32'h3048, 1'b0);
        #1 chk("blez_neg", {61'd0, bus.pc_sel}, 64'd1);
        step(1'b1, 1'b0, 4'd7, 32'h304C, 32'h8000_0000, 32'd0, 32'h304C, 1'b0);
        #1 chk("bgtz_neg", {61'd0, bus.pc_sel}, 64'd0);

        // same-cycle lookup/update: 3 taken, then 2 not taken walk 11 -> 10 -> 01
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) step(1'b1, 1'b0, 4'd1, 32'h3000, 32'h7, 32'h7, 32'h3000, 1'b0);
            else if (i < 5) step(1'b1, 1'b0, 4'd1, 32'h3000, 32'h7, 32'h8, 32'h3000, 1'b0);
            else step(1'b0, 1'b0, 4'd0, 32'h3000, 32'h0, 32'h0, 32'h3000, 1'b0);
`ifdef BRANCH_PRED_EN
            pt_exp = (i == 0 || i == 5) ? 64'd0 : 64'd1;
`else
            pt_exp = 64'd0;
`endif
            chk("bht_predict", {63'd0, pt_seen}, pt_exp);
        end

        // statistics saturation on the 4-bit instance, then clear beats increment
        do_reset();
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, 4'd5, 32'h3000 + 32'(4 * i), 32'(i + 1), 32'd0, 32'h3000, 1'b0);
        #1;
        chk("sat_s_branch_cnt", {60'd0, bus_s.branch_cnt}, 64'hF);
        chk("sat_branch_cnt", {32'd0, bus.branch_cnt}, 64'd20);
        step(1'b1, 1'b0, 4'd1, 32'h3000, 32'h1, 32'h1, 32'h3000, 1'b1);
        #1;
        chk("clr_s_branch_cnt", {60'd0, bus_s.branch_cnt}, 64'd0);
        chk("clr_branch_cnt", {32'd0, bus.branch_cnt}, 64'd0);

        // randomized traffic with a mid-run reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            b = $urandom_range(0, 3) == 0 ? 32'd0 : 32'($urandom_range(0, 8)) - 32'd4;
            case ($urandom_range(0, 3))
                0:       a = 32'd0;
                1:       a = b;
                2:       a = $urandom;
                default: a = 32'($urandom_range(0, 8)) - 32'd4;
            endcase
            p = {27'($urandom_range(0, 7)), 5'd0} << 6 | 32'($urandom_range(0, 63)) << 2;
            l = ($urandom_range(0, 1) == 1) ? p : 32'($urandom_range(0, 63)) << 2;
            o = 4'($urandom_range(0, 15));
            step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, o, p, a, b, l,
                 $urandom_range(0, 29) == 0);
        end

        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        #3 done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
